// File: rtl/control_stage_pipe.sv
// Purpose: ID-stage control decoder with registered ID/EX control word, load-use stall, flush and post-jump squash.
// Latency: one clock from op_code/formato to registered outputs; stall_out is combinational.
// Backpressure: hold freezes the ID/EX register and FSM; stall_out holds PC and IF/ID on a load-use hazard.
//
// Ports: clk/rst_n; IF/ID side id_valid, op_code, formato, id_rs, id_rt; hold (downstream freeze),
// flush (taken branch from EX); stall_out to PC/IF-ID; registered control bits, ex_valid, ex_rt, illegal_op.
module control_stage_pipe #(
    parameter int OPW          = 6,
    parameter int FUNCTW       = 6,
    parameter int REGW         = 5,
    parameter int TRUNKW       = 3,
    parameter int SQUASH_SLOTS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [OPW-1:0]    op_code,
    input  logic [FUNCTW-1:0] formato,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    input  logic              hold,
    input  logic              flush,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [REGW-1:0]   ex_rt,
    output logic              RegDst_out,
    output logic              ALUSrc_out,
    output logic              MemToReg_out,
    output logic              RegWrite_out,
    output logic              MemRead_out,
    output logic              MemWrite_out,
    output logic              Branch_out,
    output logic              Bne_out,
    output logic              Jump,
    output logic [1:0]        ALUOp_out,
    output logic [TRUNKW-1:0] trunk_mode_out,
    output logic [1:0]        Jdes_sel,
    output logic              illegal_op
);

    typedef struct packed {
        logic              reg_dst;
        logic              alu_src;
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              bne;
        logic              jump;
        logic [1:0]        alu_op;
        logic [TRUNKW-1:0] trunk;
        logic [1:0]        jdes;
    } ctrl_t;

    typedef enum logic {RUN, SQUASH} state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b001001);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
    localparam logic [OPW-1:0] OP_SLTIU = OPW'(6'b001011);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
    localparam logic [OPW-1:0] OP_XORI  = OPW'(6'b001110);
    localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b001111);
    localparam logic [OPW-1:0] OP_LB    = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_LH    = OPW'(6'b100001);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_LBU   = OPW'(6'b100100);
    localparam logic [OPW-1:0] OP_LHU   = OPW'(6'b100101);
    localparam logic [OPW-1:0] OP_LWU   = OPW'(6'b100111);
    localparam logic [OPW-1:0] OP_SB    = OPW'(6'b101000);
    localparam logic [OPW-1:0] OP_SH    = OPW'(6'b101001);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

    localparam logic [FUNCTW-1:0] FN_JR   = FUNCTW'(6'b001000);
    localparam logic [FUNCTW-1:0] FN_JALR = FUNCTW'(6'b001001);

    localparam logic       SQ_EN   = (SQUASH_SLOTS > 0);
    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_SLOTS);

    ctrl_t       dec;
    logic        dec_illegal;
    logic        dec_rt_use;   // op reads rt as a source (R-type, store, BEQ/BNE)
    ctrl_t       ctrl_q;
    state_t      state;
    logic [2:0]  sq_cnt;
    logic        hazard;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec_rt_use  = 1'b0;
        case (op_code)
            OP_RTYPE: begin
                dec_rt_use = 1'b1;
                if (formato == FN_JR) begin
                    dec.branch = 1'b1;
                    dec.jump   = 1'b1;
                    dec.jdes   = 2'b10;
                end else begin
                    dec.reg_dst   = 1'b1;
                    dec.alu_op    = 2'b10;
                    dec.reg_write = 1'b1;
                    if (formato == FN_JALR) begin
                        dec.branch = 1'b1;
                        dec.jump   = 1'b1;
                        dec.jdes   = 2'b10;
                    end
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LWU, OP_LBU, OP_LHU: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                if (op_code == OP_LB)       dec.trunk = TRUNKW'(1);
                else if (op_code == OP_LH)  dec.trunk = TRUNKW'(2);
                else if (op_code == OP_LBU) dec.trunk = TRUNKW'(3);
                else if (op_code == OP_LHU) dec.trunk = TRUNKW'(4);
            end
            OP_SB, OP_SH, OP_SW: begin
                dec_rt_use    = 1'b1;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                if (op_code == OP_SB)      dec.trunk = TRUNKW'(3);
                else if (op_code == OP_SH) dec.trunk = TRUNKW'(4);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.alu_op    = 2'b10;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_rt_use = 1'b1;
                dec.alu_op = 2'b01;
                dec.branch = 1'b1;
                dec.bne    = (op_code == OP_BNE);
            end
            OP_J: begin
                dec.branch = 1'b1;
                dec.jump   = 1'b1;
                dec.jdes   = 2'b01;
            end
            OP_JAL: begin
                dec.reg_dst   = 1'b1;
                dec.alu_op    = 2'b11;
                dec.branch    = 1'b1;
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.jdes      = 2'b01;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Load in EX whose destination is read by the instruction in ID.
    assign hazard = id_valid & ex_valid & ctrl_q.mem_read & (ex_rt != '0) &
                    ((ex_rt == id_rs) | ((ex_rt == id_rt) & dec_rt_use));

    assign stall_out = hazard & (state == RUN) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            ex_valid   <= 1'b0;
            ex_rt      <= '0;
            illegal_op <= 1'b0;
            state      <= RUN;
            sq_cnt     <= '0;
        end else if (flush) begin
            ctrl_q     <= '0;
            ex_valid   <= 1'b0;
            ex_rt      <= '0;
            illegal_op <= 1'b0;
            state      <= RUN;
            sq_cnt     <= '0;
        end else if (hold) begin
            // everything frozen
        end else if (state == SQUASH) begin
            ctrl_q     <= '0;
            ex_valid   <= 1'b0;
            ex_rt      <= '0;
            illegal_op <= 1'b0;
            sq_cnt     <= sq_cnt - 3'd1;
            if (sq_cnt <= 3'd1) begin
                state  <= RUN;
                sq_cnt <= '0;
            end
        end else if (hazard || !id_valid) begin
            ctrl_q     <= '0;
            ex_valid   <= 1'b0;
            ex_rt      <= '0;
            illegal_op <= 1'b0;
        end else begin
            ctrl_q     <= dec;
            ex_valid   <= 1'b1;
            ex_rt      <= id_rt;
            illegal_op <= dec_illegal;
            if (dec.jump && SQ_EN) begin
                state  <= SQUASH;
                sq_cnt <= SQ_LOAD;
            end
        end
    end

    assign RegDst_out     = ctrl_q.reg_dst;
    assign ALUSrc_out     = ctrl_q.alu_src;
    assign MemToReg_out   = ctrl_q.mem_to_reg;
    assign RegWrite_out   = ctrl_q.reg_write;
    assign MemRead_out    = ctrl_q.mem_read;
    assign MemWrite_out   = ctrl_q.mem_write;
    assign Branch_out     = ctrl_q.branch;
    assign Bne_out        = ctrl_q.bne;
    assign Jump           = ctrl_q.jump;
    assign ALUOp_out      = ctrl_q.alu_op;
    assign trunk_mode_out = ctrl_q.trunk;
    assign Jdes_sel       = ctrl_q.jdes;

endmodule

// File: tb/tb_control_stage_pipe.sv
// Purpose: directed self-checking bench for control_stage_pipe (SQUASH_SLOTS=2).
// Latency: checks registered outputs 1 time unit after each rising edge.
// Backpressure: exercises hold, flush and load-use stall directly.
module tb_control_stage_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] op_code;
    logic [5:0] formato;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       hold;
    logic       flush;
    logic       stall_out;
    logic       ex_valid;
    logic [4:0] ex_rt;
    logic       RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out;
    logic       MemWrite_out, Branch_out, Bne_out, Jump;
    logic [1:0] ALUOp_out;
    logic [2:0] trunk_mode_out;
    logic [1:0] Jdes_sel;
    logic       illegal_op;

    int errors = 0;
    int checks = 0;

    control_stage_pipe #(
        .OPW(6), .FUNCTW(6), .REGW(5), .TRUNKW(3), .SQUASH_SLOTS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op_code(op_code),
        .formato(formato), .id_rs(id_rs), .id_rt(id_rt), .hold(hold),
        .flush(flush), .stall_out(stall_out), .ex_valid(ex_valid), .ex_rt(ex_rt),
        .RegDst_out(RegDst_out), .ALUSrc_out(ALUSrc_out), .MemToReg_out(MemToReg_out),
        .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .Branch_out(Branch_out), .Bne_out(Bne_out), .Jump(Jump), .ALUOp_out(ALUOp_out),
        .trunk_mode_out(trunk_mode_out), .Jdes_sel(Jdes_sel), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Observed control word: RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,Bne,Jump,ALUOp,trunk,Jdes
    logic [15:0] cw_o;
    assign cw_o = {RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out,
                   MemWrite_out, Branch_out, Bne_out, Jump, ALUOp_out, trunk_mode_out, Jdes_sel};

    function automatic logic [15:0] cw(input logic rd, as, mtr, rw, mr, mw, br, bn, j,
                                       input logic [1:0] aop, input logic [2:0] tr,
                                       input logic [1:0] jd);
        return {rd, as, mtr, rw, mr, mw, br, bn, j, aop, tr, jd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt);
        id_valid = v;
        op_code  = op;
        formato  = fn;
        id_rs    = rs;
        id_rt    = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] W_LW, W_ADD, W_ADDI, W_J, W_LHU, W_JAL, W_SW, W_BNE, W_LB;

    initial begin
        W_LW   = cw(0,1,1,1,1,0,0,0,0,2'b00,3'd0,2'b00);
        W_ADD  = cw(1,0,0,1,0,0,0,0,0,2'b10,3'd0,2'b00);
        W_ADDI = cw(0,1,0,1,0,0,0,0,0,2'b10,3'd0,2'b00);
        W_J    = cw(0,0,0,0,0,0,1,0,1,2'b00,3'd0,2'b01);
        W_LHU  = cw(0,1,1,1,1,0,0,0,0,2'b00,3'd4,2'b00);
        W_JAL  = cw(1,0,0,1,0,0,1,0,1,2'b11,3'd0,2'b01);
        W_SW   = cw(0,1,0,0,0,1,0,0,0,2'b00,3'd0,2'b00);
        W_BNE  = cw(0,0,0,0,0,0,1,1,0,2'b01,3'd0,2'b00);
        W_LB   = cw(0,1,1,1,1,0,0,0,0,2'b00,3'd1,2'b00);

        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        drv(0, 6'b000000, 6'b000000, 5'd0, 5'd0);
        #1;
        chk("reset_cw", cw_o, 16'h0);
        chk("reset_exv", ex_valid, 0);
        chk("reset_stall", stall_out, 0);
        chk("reset_illegal", illegal_op, 0);
        #1 rst_n = 1'b1;

        // LW r3, then ADD r4,r3,r5 -> one bubble
        drv(1, 6'b100011, 6'b000000, 5'd1, 5'd3);
        tick();
        chk("lw_cw", cw_o, W_LW);
        chk("lw_exrt", ex_rt, 5'd3);
        drv(1, 6'b000000, 6'b100000, 5'd3, 5'd5);
        #1;
        chk("lu_stall", stall_out, 1);
        tick();
        chk("lu_bubble_cw", cw_o, 16'h0);
        chk("lu_bubble_exv", ex_valid, 0);
        chk("lu_stall_clear", stall_out, 0);
        tick();
        chk("lu_add_cw", cw_o, W_ADD);
        chk("lu_add_exrt", ex_rt, 5'd5);

        // LW to r0 never stalls
        drv(1, 6'b100011, 6'b000000, 5'd1, 5'd0);
        tick();
        drv(1, 6'b000000, 6'b100000, 5'd0, 5'd0);
        #1;
        chk("r0_nostall", stall_out, 0);
        tick();
        chk("r0_add_cw", cw_o, W_ADD);

        // LW r7 then ADDI with rt=7 (rt is a destination) -> no stall
        drv(1, 6'b100011, 6'b000000, 5'd1, 5'd7);
        tick();
        drv(1, 6'b001000, 6'b000000, 5'd2, 5'd7);
        #1;
        chk("addi_rt_nostall", stall_out, 0);
        // LW r7 then SW with rt=7 (store data) -> stall
        drv(1, 6'b101011, 6'b000000, 5'd2, 5'd7);
        #1;
        chk("sw_rt_stall", stall_out, 1);
        tick();
        chk("sw_rt_bubble", ex_valid, 0);

        // J with two squash slots
        drv(1, 6'b000010, 6'b000000, 5'd0, 5'd0);
        tick();
        chk("j_cw", cw_o, W_J);
        drv(1, 6'b001000, 6'b000000, 5'd1, 5'd2);
        #1;
        chk("j_stall0", stall_out, 0);
        tick();
        chk("sq1_cw", cw_o, 16'h0);
        chk("sq1_exv", ex_valid, 0);
        chk("sq1_stall", stall_out, 0);
        tick();
        chk("sq2_cw", cw_o, 16'h0);
        chk("sq2_exv", ex_valid, 0);
        tick();
        chk("post_sq_addi", cw_o, W_ADDI);

        // LHU held 3 cycles, then flush wins over hold
        drv(1, 6'b100101, 6'b000000, 5'd1, 5'd2);
        tick();
        chk("lhu_cw", cw_o, W_LHU);
        hold = 1'b1;
        drv(1, 6'b000000, 6'b100000, 5'd9, 5'd10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_trunk", trunk_mode_out, 3'd4);
            chk("hold_exv", ex_valid, 1);
        end
        flush = 1'b1;
        tick();
        chk("flush_hold_cw", cw_o, 16'h0);
        chk("flush_hold_exv", ex_valid, 0);
        hold = 1'b0; flush = 1'b0;

        // JAL then flush inside squash window
        drv(1, 6'b000011, 6'b000000, 5'd0, 5'd0);
        tick();
        chk("jal_cw", cw_o, W_JAL);
        drv(1, 6'b101011, 6'b000000, 5'd1, 5'd4);
        flush = 1'b1;
        tick();
        chk("sqflush_cw", cw_o, 16'h0);
        flush = 1'b0;
        tick();
        chk("sqflush_sw_cw", cw_o, W_SW);
        chk("sqflush_sw_exv", ex_valid, 1);

        // BNE and LB
        drv(1, 6'b000101, 6'b000000, 5'd1, 5'd2);
        tick();
        chk("bne_cw", cw_o, W_BNE);
        drv(1, 6'b100000, 6'b000000, 5'd1, 5'd6);
        tick();
        chk("lb_cw", cw_o, W_LB);

        // Illegal opcode
        drv(1, 6'b111111, 6'b000000, 5'd0, 5'd0);
        tick();
        chk("ill_cw", cw_o, 16'h0);
        chk("ill_pulse", illegal_op, 1);
        chk("ill_exv", ex_valid, 1);
        drv(0, 6'b111111, 6'b000000, 5'd0, 5'd0);
        tick();
        chk("ill_novalid", illegal_op, 0);
        chk("ill_novalid_exv", ex_valid, 0);

        // Async reset mid-stream with LW registered
        drv(1, 6'b100011, 6'b000000, 5'd1, 5'd3);
        tick();
        chk("pre_rst_lw", cw_o, W_LW);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cw", cw_o, 16'h0);
        chk("async_rst_exv", ex_valid, 0);
        chk("async_rst_exrt", ex_rt, 5'd0);
        #2 rst_n = 1'b1;
        drv(1, 6'b001000, 6'b000000, 5'd1, 5'd2);
        tick();
        chk("post_rst_addi", cw_o, W_ADDI);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_stage_pipe.md
Name: control_stage_pipe

Overview:
- Parametrised successor to the combinational ID-stage control decoder.
- Decodes op_code/formato into the pipeline control word and registers it into the ID/EX control register.
- Adds in-block load-use hazard detection with stall generation, taken-branch flush, and a configurable post-jump squash window.
- Sits between the IF/ID register and the EX stage; drives stall_out back to the PC and IF/ID registers.

Parameters:
OPW, 6, opcode field width
FUNCTW, 6, funct (formato) field width
REGW, 5, register index width
TRUNKW, 3, trunk_mode width (values 0..4 used)
SQUASH_SLOTS, 1, bubbles inserted after a decoded jump (0..7; 0 disables squash)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
op_code  in  OPW  instruction opcode
formato  in  FUNCTW  funct field
id_rs  in  REGW  source register rs
id_rt  in  REGW  source register rt / load destination
hold  in  1  downstream freeze; ID/EX register keeps its value
flush  in  1  EX resolved a taken branch; squash ID
stall_out  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  ID/EX slot holds a real instruction
ex_rt  out  REGW  registered id_rt
RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out, Bne_out, Jump  out  1 each  registered control bits
ALUOp_out  out  2  registered ALU op class
trunk_mode_out  out  TRUNKW  registered trunk mode (0 normal, 1 byte signed, 2 half signed, 3 byte unsigned, 4 half unsigned)
Jdes_sel  out  2  registered jump target select (1 immediate, 2 register)
illegal_op  out  1  registered one-cycle pulse for an undecodable opcode with id_valid

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs 0; FSM in RUN; squash counter 0. Deassertion takes effect on the next rising edge.
- Decode table (combinational, then registered):
  - R-type: RegDst=1, ALUOp=10, RegWrite=1.
  - JR (funct 001000): Branch=1, Jump=1, Jdes=10.
  - JALR (funct 001001): R-type bits plus Branch=1, Jump=1, Jdes=10.
  - LB/LH/LW/LWU/LBU/LHU (100000/100001/100011/100111/100100/100101): ALUSrc=1, MemRead=1, RegWrite=1, MemToReg=1. Trunk modes 1/2/0/0/3/4.
  - SB/SH/SW (101000/101001/101011): ALUSrc=1, MemWrite=1. Trunk modes 3/4/0.
  - ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI (001000..001111): ALUOp=10, ALUSrc=1, RegWrite=1.
  - BEQ (000100): ALUOp=01, Branch=1. BNE (000101): same as BEQ plus Bne=1.
  - J (000010): Branch=1, Jump=1, Jdes=01.
  - JAL (000011): RegDst=1, ALUOp=11, Branch=1, RegWrite=1, Jump=1, Jdes=01, trunk=0.
  - Any other opcode: NOP word.
  - Every bit not listed for an opcode is 0.
- Bubble: all control bits 0, ex_valid=0, ex_rt=0.
- Load-use hazard (combinational): hazard = id_valid & ex_valid & MemRead_out & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt & the decoded op is R-type, a store, or BEQ/BNE)).
- stall_out = hazard & state==RUN & !flush.
- Per-edge ID/EX update, highest priority first:
  1. flush: load bubble; state→RUN; counter←0. Flush overrides hold.
  2. hold: all registers keep their value; FSM and counter frozen.
  3. state==SQUASH: load bubble; decrement counter; at 1→0 go to RUN.
  4. hazard: load bubble. IF/ID is held by stall_out, so the instruction re-decodes next cycle.
  5. Otherwise: load the decoded word; ex_valid←id_valid; ex_rt←id_rt.
     - If id_valid and the decoded Jump=1 and SQUASH_SLOTS>0: state→SQUASH, counter←SQUASH_SLOTS.
- !id_valid in case 5 loads a bubble.
- illegal_op ← id_valid & undecodable opcode, only in case 5; 0 otherwise.
- Latency: one clock from decode to the registered outputs. A load-use stall costs exactly one bubble.

Test Plan:
- Reset mid-stream with LW registered: assert rst_n=0 asynchronously → all outputs 0 before the next edge; after release, first ADDI decodes to ALUOp=10, ALUSrc=1, RegWrite=1.
- LW r3 followed by ADD r4,r3,r5 → cycle 1 LW word (trunk 0, MemRead=1); cycle 2 stall_out=1 and a bubble; cycle 3 ADD word (RegDst=1). With ex_rt=0 there is no stall.
- J with SQUASH_SLOTS=2 → J word (Jdes=01), then 2 bubble cycles, then the next decoded instruction; stall_out stays 0 throughout.
- hold=1 for 3 cycles during LHU → trunk_mode_out stays 4, ex_valid stays 1; flush asserted together with hold → bubble on that edge.
- flush during the SQUASH window → bubble, state RUN, and the next valid SW decodes on the following edge (MemWrite=1).
- op_code 111111 with id_valid=1 → NOP word and a one-cycle illegal_op pulse; with id_valid=0 → no pulse.
